// File: rtl/mbist_march_ctrl_pkg.sv
// Shared March C- definitions: op encoding, per-element op lists, direction and FSM states.
package mbist_march_ctrl_pkg;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  // bit1 = write, bit0 = data value (written or expected)
  typedef enum logic [1:0] {OP_R0 = 2'b00, OP_R1 = 2'b01, OP_W0 = 2'b10, OP_W1 = 2'b11} op_e;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3} state_e;

  function automatic op_e elem_op(input logic [2:0] elem, input logic idx);
    op_e op;
    case (elem)
      3'd0:       op = OP_W0;
      3'd1, 3'd3: op = idx ? OP_W1 : OP_R0;
      3'd2, 3'd4: op = idx ? OP_W0 : OP_R1;
      default:    op = OP_R0;
    endcase
    return op;
  endfunction

  function automatic logic elem_down(input logic [2:0] elem);
    return (elem == 3'd3) || (elem == 3'd4);
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] elem);
    return (elem >= 3'd1) && (elem <= 3'd4);
  endfunction
endpackage

// File: rtl/march_seq.sv
// March C- sequencer: walks element / address / op-within-element, one op per step.
module march_seq
  import mbist_march_ctrl_pkg::*;
#(
  parameter int AWIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_step,
  output logic [AWIDTH-1:0] o_addr,
  output logic [2:0]        o_elem,
  output op_e               o_op,
  output logic              o_last
);
  logic [AWIDTH-1:0] r_addr;
  logic [2:0]        r_elem;
  logic              r_idx;
  logic              w_down;
  logic              w_op_last;
  logic              w_at_end;
  logic [AWIDTH-1:0] w_end;
  logic [2:0]        w_elem_nxt;

  always_comb begin
    w_down     = elem_down(r_elem);
    w_end      = w_down ? '0 : '1;
    w_op_last  = !elem_two_ops(r_elem) || r_idx;
    w_at_end   = (r_addr == w_end);
    w_elem_nxt = r_elem + 3'd1;
    o_addr     = r_addr;
    o_elem     = r_elem;
    o_op       = elem_op(r_elem, r_idx);
    o_last     = (r_elem == LAST_ELEM) && w_op_last && w_at_end;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
      r_elem <= '0;
      r_idx  <= 1'b0;
    end else if (i_init) begin
      r_addr <= '0;
      r_elem <= '0;
      r_idx  <= 1'b0;
    end else if (i_step) begin
      if (!w_op_last) begin
        r_idx <= 1'b1;
      end else begin
        r_idx <= 1'b0;
        // Address wrap moves to the next element, reloaded at that element's start end.
        if (w_at_end) begin
          r_elem <= w_elem_nxt;
          r_addr <= elem_down(w_elem_nxt) ? '1 : '0;
        end else begin
          r_addr <= w_down ? r_addr - 1'b1 : r_addr + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: run FSM, one-stage read compare, fail counter and first-fail capture.
module mbist_march_ctrl
  import mbist_march_ctrl_pkg::*;
#(
  parameter int AWIDTH       = 4,
  parameter bit STOP_ON_FAIL = 1'b0,
  parameter int FCW          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [AWIDTH-1:0] o_wr_addr,
  output logic [AWIDTH-1:0] o_rd_addr,
  output logic              o_data_in,
  output logic              o_we,
  output logic              o_re,
  input  logic              i_data_out,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [FCW-1:0]    o_fail_count,
  output logic [AWIDTH-1:0] o_first_fail_addr,
  output logic [2:0]        o_first_fail_elem
);
  state_e            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_wr_addr, r_rd_addr;
  logic              r_vld, r_exp;
  logic [AWIDTH-1:0] r_paddr;
  logic [2:0]        r_pelem;
  logic [FCW-1:0]    r_fail_count;
  logic [AWIDTH-1:0] r_ffa;
  logic [2:0]        r_ffe;
  logic              r_pass;

  logic              w_accept, w_miscmp, w_stop, w_issue;
  logic [AWIDTH-1:0] w_seq_addr;
  logic [2:0]        w_seq_elem;
  op_e               w_op;
  logic              w_last;

  march_seq #(.AWIDTH(AWIDTH)) u_seq (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_init  (w_accept),
    .i_step  (w_issue),
    .o_addr  (w_seq_addr),
    .o_elem  (w_seq_elem),
    .o_op    (w_op),
    .o_last  (w_last)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_miscmp = r_vld && (i_data_out != r_exp);
  assign w_stop   = STOP_ON_FAIL && w_miscmp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:   if (w_stop) w_state_nxt = ST_DONE;
                else if (w_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // On a stop-on-fail miscompare the op in the compare cycle is suppressed.
  always_comb begin
    o_busy    = (r_state != ST_IDLE);
    o_done    = (r_state == ST_DONE);
    w_issue   = (r_state == ST_RUN) && !w_stop;
    o_re      = w_issue && !w_op[1];
    o_we      = w_issue && w_op[1];
    o_data_in = o_we && w_op[0];
    o_rd_addr = o_re ? w_seq_addr : r_rd_addr;
    o_wr_addr = o_we ? w_seq_addr : r_wr_addr;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_vld     <= 1'b0;
      r_exp     <= 1'b0;
      r_paddr   <= '0;
      r_pelem   <= '0;
    end else begin
      r_wr_addr <= o_wr_addr;
      r_rd_addr <= o_rd_addr;
      r_vld     <= o_re;
      r_exp     <= w_op[0];
      if (o_re) begin
        r_paddr <= w_seq_addr;
        r_pelem <= w_seq_elem;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fail_count <= '0;
      r_ffa        <= '0;
      r_ffe        <= '0;
      r_pass       <= 1'b0;
    end else if (w_accept) begin
      r_fail_count <= '0;
      r_ffa        <= '0;
      r_ffe        <= '0;
      r_pass       <= 1'b0;
    end else begin
      if (w_miscmp) begin
        if (!(&r_fail_count)) r_fail_count <= r_fail_count + 1'b1;
        if (r_fail_count == '0) begin
          r_ffa <= r_paddr;
          r_ffe <= r_pelem;
        end
      end
      if ((w_state_nxt == ST_DONE) && (r_state != ST_DONE))
        r_pass <= (r_fail_count == '0) && !w_miscmp;
    end
  end

  assign o_pass            = r_pass;
  assign o_fail_count      = r_fail_count;
  assign o_first_fail_addr = r_ffa;
  assign o_first_fail_elem = r_ffe;
endmodule
